// File: rtl/fft_bfly_r2_if.sv
// Sample/twiddle and result bundle for the radix-2 butterfly.
// master = upstream source driving A/B/W; slave = the butterfly itself.
interface fft_bfly_r2_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic signed [DW-1:0] a_r, a_i;
  logic signed [DW-1:0] b_r, b_i;
  logic signed [DW-1:0] w_r, w_i;
  logic                 ovf_clr;
  logic                 out_valid;
  logic signed [DW-1:0] x_r, x_i;
  logic signed [DW-1:0] y_r, y_i;
  logic                 ovf;

  modport master (
    output in_valid, a_r, a_i, b_r, b_i, w_r, w_i, ovf_clr,
    input  out_valid, x_r, x_i, y_r, y_i, ovf
  );

  modport slave (
    input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i, ovf_clr,
    output out_valid, x_r, x_i, y_r, y_i, ovf
  );
endinterface

// File: rtl/fft_bfly_r2.sv
// 3-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with sticky saturation flag.
// Define FFT_BFLY_SCALE_EN to halve the stage-3 sums (round half-up) instead of saturating.
module fft_bfly_r2 #(
  parameter int DW  = 16,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  fft_bfly_r2_if.slave bus
);
  localparam int PW = 2*DW;
  localparam int TW = 2*DW+1;
  localparam int SW = DW+1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  generate
    if (LAT != 3) begin : g_lat_chk
      $error("fft_bfly_r2: LAT must be 3");
    end
  endgenerate

  // Round half-up from Q2.30 back to Q1.15, then clamp; returns {clip, value}.
  function automatic logic [DW:0] sat_t(input logic signed [TW-1:0] v);
    logic signed [TW-1:0] q;
    q = (v + TW'(1 << (DW-2))) >>> (DW-1);
    if ((&q[TW-1:DW-1]) || !(|q[TW-1:DW-1]))
      return {1'b0, q[DW-1:0]};
    return {1'b1, q[TW-1], {(DW-1){~q[TW-1]}}};
  endfunction

  logic [LAT:1]         vld_pipe;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  cplx_t                a1, a2, t2;
  logic [DW:0]          st_r, st_i;
  logic                 ev2, ev3;
  logic signed [SW-1:0] sx_r, sx_i, sy_r, sy_i;
  logic signed [DW-1:0] x_r_n, x_i_n, y_r_n, y_i_n;
  logic signed [DW-1:0] x_r_q, x_i_q, y_r_q, y_i_q;
  logic                 ovf_q;

  always_comb begin
    st_r = sat_t(TW'(p_rr) - TW'(p_ii));
    st_i = sat_t(TW'(p_ri) + TW'(p_ir));
    ev2  = st_r[DW] | st_i[DW];
    sx_r = SW'(a2.re) + SW'(t2.re);
    sx_i = SW'(a2.im) + SW'(t2.im);
    sy_r = SW'(a2.re) - SW'(t2.re);
    sy_i = SW'(a2.im) - SW'(t2.im);
  end

`ifdef FFT_BFLY_SCALE_EN
  // Halving a DW+1 sum always lands back in DW bits, so no clip is possible here.
  always_comb begin
    x_r_n = DW'((sx_r + SW'(1)) >>> 1);
    x_i_n = DW'((sx_i + SW'(1)) >>> 1);
    y_r_n = DW'((sy_r + SW'(1)) >>> 1);
    y_i_n = DW'((sy_i + SW'(1)) >>> 1);
    ev3   = 1'b0;
  end
`else
  function automatic logic [DW:0] sat_s(input logic signed [SW-1:0] v);
    if (v[SW-1] == v[SW-2])
      return {1'b0, v[DW-1:0]};
    return {1'b1, v[SW-1], {(DW-1){~v[SW-1]}}};
  endfunction

  logic c_xr, c_xi, c_yr, c_yi;

  always_comb begin
    {c_xr, x_r_n} = sat_s(sx_r);
    {c_xi, x_i_n} = sat_s(sx_i);
    {c_yr, y_r_n} = sat_s(sy_r);
    {c_yi, y_i_n} = sat_s(sy_i);
    ev3 = c_xr | c_xi | c_yr | c_yi;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
      a1       <= '0;
      a2       <= '0;
      t2       <= '0;
      x_r_q    <= '0;
      x_i_q    <= '0;
      y_r_q    <= '0;
      y_i_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:1], bus.in_valid};
      if (bus.in_valid) begin
        p_rr <= PW'(bus.b_r) * PW'(bus.w_r);
        p_ii <= PW'(bus.b_i) * PW'(bus.w_i);
        p_ri <= PW'(bus.b_r) * PW'(bus.w_i);
        p_ir <= PW'(bus.b_i) * PW'(bus.w_r);
        a1   <= '{re: bus.a_r, im: bus.a_i};
      end
      if (vld_pipe[1]) begin
        a2 <= a1;
        t2 <= '{re: st_r[DW-1:0], im: st_i[DW-1:0]};
      end
      if (vld_pipe[2]) begin
        x_r_q <= x_r_n;
        x_i_q <= x_i_n;
        y_r_q <= y_r_n;
        y_i_q <= y_i_n;
      end
      // A fresh clip outranks a same-cycle clear so no event is ever lost.
      if ((vld_pipe[1] && ev2) || (vld_pipe[2] && ev3))
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_pipe[LAT];
  assign bus.x_r       = x_r_q;
  assign bus.x_i       = x_i_q;
  assign bus.y_r       = y_r_q;
  assign bus.y_i       = y_i_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_bfly_r2.sv
// Scoreboard bench for fft_bfly_r2: directed vectors push expected X/Y, a negedge monitor pops and checks.
module tb_fft_bfly_r2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bfly_r2_if #(.DW(16)) bus ();
  fft_bfly_r2 #(.DW(16), .LAT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int xr; int xi; int yr; int yi;} exp_t;
  exp_t q[$];
  exp_t last;
  logic [2:0] hist = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Final output from an unclipped A+/-T sum.
  function automatic int fin(input int s);
`ifdef FFT_BFLY_SCALE_EN
    return (s + 1) >>> 1;
`else
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`endif
  endfunction

  // Sums sx/sy are the hand-computed A+T / A-T before final saturation or scaling.
  task automatic send(input int ar, ai, br, bi, wr, wi, sxr, sxi, syr, syi);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_r = 16'(ar); bus.a_i = 16'(ai);
    bus.b_r = 16'(br); bus.b_i = 16'(bi);
    bus.w_r = 16'(wr); bus.w_i = 16'(wi);
    e.xr = fin(sxr); e.xi = fin(sxi); e.yr = fin(syr); e.yi = fin(syi);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Reference valid delay line; reset also discards anything still expected.
  always @(posedge clk) begin
    if (rst) begin
      hist = '0;
      q.delete();
      last = '{0, 0, 0, 0};
    end else begin
      hist = {hist[1:0], bus.in_valid};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", int'(bus.out_valid), int'(hist[2]));
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x_r", int'(bus.x_r), e.xr);
        chk("x_i", int'(bus.x_i), e.xi);
        chk("y_r", int'(bus.y_r), e.yr);
        chk("y_i", int'(bus.y_i), e.yi);
        last = e;
      end
    end else begin
      chk("hold_x_r", int'(bus.x_r), last.xr);
      chk("hold_x_i", int'(bus.x_i), last.xi);
      chk("hold_y_r", int'(bus.y_r), last.yr);
      chk("hold_y_i", int'(bus.y_i), last.yi);
    end
  end

  initial begin
    last = '{0, 0, 0, 0};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ovf_clr = 1'b0;
    bus.a_r = '0; bus.a_i = '0; bus.b_r = '0; bus.b_i = '0; bus.w_r = '0; bus.w_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ovf", int'(bus.ovf), 0);

    // T = (2000,0) after rounding 2000*32767.
    send(1000, 0, 2000, 0, 32767, 0, 3000, 0, -1000, 0);
    idle(4);
    chk("ovf_t1", int'(bus.ovf), 0);

    // j*1000 times -j gives T = (1000,0).
    send(0, 0, 0, 1000, 0, -32768, 1000, 0, -1000, 0);
    idle(4);
    chk("ovf_t2", int'(bus.ovf), 0);

    // T = 29999; X sum 59999 clips unless halved.
    send(30000, 0, 30000, 0, 32767, 0, 59999, 0, 1, 0);
    idle(4);
`ifdef FFT_BFLY_SCALE_EN
    chk("ovf_t3", int'(bus.ovf), 0);
`else
    chk("ovf_t3", int'(bus.ovf), 1);
`endif
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    chk("ovf_clr_t3", int'(bus.ovf), 0);

    // (-1)*(-1) rounds to +32768 and clips to 32767 in stage 2.
    send(0, 0, -32768, 0, -32768, 0, 32767, 0, -32767, 0);
    idle(4);
    chk("ovf_t4", int'(bus.ovf), 1);
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    chk("ovf_clr_t4", int'(bus.ovf), 0);

    @(negedge clk); bus.ovf_clr = 1'b1;
    send(0, 0, -32768, 0, -32768, 0, 32767, 0, -32767, 0);
    idle(2);
    chk("ovf_set_wins", int'(bus.ovf), 1);
    idle(1);
    chk("ovf_clr_held", int'(bus.ovf), 0);
    bus.ovf_clr = 1'b0;
    idle(3);

    // W = 0.5: B=(20i,10i) gives T=(10i,5i), A=(100i,-50i).
    for (int i = 1; i <= 8; i++)
      send(100*i, -50*i, 20*i, 10*i, 16384, 0, 110*i, -45*i, 90*i, -55*i);
    idle(2);
    for (int i = 9; i <= 11; i++)
      send(100*i, -50*i, 20*i, 10*i, 16384, 0, 110*i, -45*i, 90*i, -55*i);
    idle(5);

    // Reset with samples in flight; the middle one has already raised ovf.
    send(100, -50, 20, 10, 16384, 0, 110, -45, 90, -55);
    send(0, 0, -32768, 0, -32768, 0, 32767, 0, -32767, 0);
    send(300, -150, 60, 30, 16384, 0, 330, -135, 270, -165);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    chk("ovf_pre_rst", int'(bus.ovf), 1);
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_post_rst", int'(bus.ovf), 0);
    idle(6);
    chk("ovf_flushed", int'(bus.ovf), 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
